// File: rtl/wishbone_1mst_to_nslv_reg.sv
// Registered Wishbone classic 1-master to N-slave splitter: first-match decode, bus-error reply.
// Define WB_SPLIT_TIMEOUT_EN to build the REQ watchdog that turns a hung slave into an error reply.
module wishbone_1mst_to_nslv_reg #(
    parameter int unsigned            NB_SLV   = 4,
    parameter logic [NB_SLV*32-1:0]   ADDR_TAB = {32'h3003_0000, 32'h3002_0000,
                                                  32'h3001_0000, 32'h3000_0000},
    parameter logic [NB_SLV*32-1:0]   MASK_TAB = {4{32'hFFFF_0000}},
    parameter logic [31:0]            ERR_DATA = 32'hBADA_DD00,
    parameter int unsigned            TIMEOUT  = 255
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_n_i,
    input  logic                     wbs_m_cyc_i,
    input  logic                     wbs_m_stb_i,
    input  logic [31:0]              wbs_m_adr_i,
    input  logic                     wbs_m_we_i,
    input  logic [31:0]              wbs_m_dat_i,
    input  logic [3:0]               wbs_m_sel_i,
    output logic [31:0]              wbs_m_dat_o,
    output logic                     wbs_m_ack_o,
    output logic [NB_SLV-1:0]        wbs_s_cyc_o,
    output logic [NB_SLV-1:0]        wbs_s_stb_o,
    output logic [31:0]              wbs_s_adr_o,
    output logic                     wbs_s_we_o,
    output logic [31:0]              wbs_s_dat_o,
    output logic [3:0]               wbs_s_sel_o,
    input  logic [32*NB_SLV-1:0]     wbs_s_dat_i,
    input  logic [NB_SLV-1:0]        wbs_s_ack_i,
    output logic                     bus_err_o,
    output logic [7:0]               err_cnt_o
);

    localparam int unsigned DW          = 32;
    localparam int unsigned CW          = 8;
    localparam int unsigned WDW         = 16;
    localparam logic [CW-1:0] ERR_CNT_MAX = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [NB_SLV-1:0]   sel_q, sel_d;
    logic [NB_SLV-1:0]   req_q, req_d;
    logic                m_ack_q, m_ack_d;
    logic                bus_err_q, bus_err_d;
    logic [DW-1:0]       m_dat_q, m_dat_d;
    logic [CW-1:0]       err_cnt_q, err_cnt_d;

    logic [NB_SLV-1:0]   raw_hit_c;
    logic [NB_SLV-1:0]   hit_c;
    logic [DW-1:0]       rdata_c;
    logic                ack_hit_c;
    logic                start_c;
    logic                timeout_c;

    // Address decode against every window; lowest index wins on overlap.
    always_comb begin
        raw_hit_c = '0;
        for (int unsigned i = 0; i < NB_SLV; i++) begin
            raw_hit_c[i] = (wbs_m_adr_i & MASK_TAB[32*i +: 32]) ==
                           (ADDR_TAB[32*i +: 32] & MASK_TAB[32*i +: 32]);
        end
    end

    assign hit_c = raw_hit_c & (~raw_hit_c + NB_SLV'(1));

    // Read data of the latched slave; sel_q is one-hot so an OR-mux suffices.
    always_comb begin
        rdata_c = '0;
        for (int unsigned i = 0; i < NB_SLV; i++) begin
            if (sel_q[i]) begin
                rdata_c = rdata_c | wbs_s_dat_i[DW*i +: DW];
            end
        end
    end

    assign ack_hit_c = |(wbs_s_ack_i & sel_q);

    // m_ack_q is still high in the first IDLE cycle after a reply; the master
    // has not yet had a chance to drop stb, so that cycle must not start a new access.
    assign start_c = wbs_m_cyc_i & wbs_m_stb_i & ~m_ack_q;

`ifdef WB_SPLIT_TIMEOUT_EN
    logic [WDW-1:0] wdog_q, wdog_d;

    always_comb begin
        wdog_d = '0;
        if (state_q == ST_REQ) begin
            wdog_d = wdog_q + WDW'(1);
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end

    assign timeout_c = (wdog_q == WDW'(TIMEOUT - 1));
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = TIMEOUT;
    assign timeout_c      = 1'b0;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        req_d     = '0;
        m_ack_d   = 1'b0;
        bus_err_d = 1'b0;
        m_dat_d   = m_dat_q;
        err_cnt_d = err_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_c) begin
                    sel_d = hit_c;
                    if (|hit_c) begin
                        state_d = ST_REQ;
                        req_d   = hit_c;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_REQ: begin
                if (!wbs_m_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (ack_hit_c) begin
                    state_d = ST_RESP;
                    m_dat_d = rdata_c;
                end else if (timeout_c) begin
                    state_d = ST_ERR;
                end else begin
                    req_d = sel_q;
                end
            end
            ST_RESP: begin
                m_ack_d = 1'b1;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                m_ack_d   = 1'b1;
                bus_err_d = 1'b1;
                m_dat_d   = ERR_DATA;
                if (err_cnt_q != ERR_CNT_MAX) begin
                    err_cnt_d = err_cnt_q + CW'(1);
                end
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            req_q     <= '0;
            m_ack_q   <= 1'b0;
            bus_err_q <= 1'b0;
            m_dat_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            req_q     <= req_d;
            m_ack_q   <= m_ack_d;
            bus_err_q <= bus_err_d;
            m_dat_q   <= m_dat_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign wbs_m_dat_o = m_dat_q;
    assign wbs_m_ack_o = m_ack_q;
    assign bus_err_o   = bus_err_q;
    assign err_cnt_o   = err_cnt_q;
    assign wbs_s_cyc_o = req_q;
    assign wbs_s_stb_o = req_q;

    // Shared slave-side bus is a straight pass-through of the master.
    assign wbs_s_adr_o = wbs_m_adr_i;
    assign wbs_s_we_o  = wbs_m_we_i;
    assign wbs_s_dat_o = wbs_m_dat_i;
    assign wbs_s_sel_o = wbs_m_sel_i;

endmodule

// File: tb/tb_wishbone_1mst_to_nslv_reg.sv
// Directed self-checking bench for wishbone_1mst_to_nslv_reg (default map plus an overlapping-map copy).
module tb_wishbone_1mst_to_nslv_reg;

    localparam int unsigned NB = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              m_cyc, m_stb, m_we;
    logic [31:0]       m_adr, m_wdat;
    logic [3:0]        m_sel;
    logic [31:0]       m_rdat;
    logic              m_ack;
    logic [NB-1:0]     s_cyc, s_stb, s_ack;
    logic [31:0]       s_adr, s_wdat;
    logic              s_we;
    logic [3:0]        s_sel;
    logic [NB*32-1:0]  s_rdat;
    logic              bus_err;
    logic [7:0]        err_cnt;

    logic [31:0]       o_rdat;
    logic              o_ack;
    logic [NB-1:0]     o_scyc, o_sstb, o_sack;
    logic [31:0]       o_sadr, o_swdat;
    logic              o_swe;
    logic [3:0]        o_ssel;
    logic              o_err;
    logic [7:0]        o_cnt;

    logic [NB-1:0]     ack_en, spur_ack;
    logic [31:0]       slv_dat [NB];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Zero-wait slaves (gated by ack_en) plus a spurious-ack injector.
    assign s_ack  = (s_stb & ack_en) | spur_ack;
    assign o_sack = (o_sstb & ack_en) | spur_ack;
    assign s_rdat = {slv_dat[3], slv_dat[2], slv_dat[1], slv_dat[0]};

    wishbone_1mst_to_nslv_reg #(.NB_SLV(NB), .TIMEOUT(16)) u_dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .wbs_m_cyc_i(m_cyc), .wbs_m_stb_i(m_stb), .wbs_m_adr_i(m_adr),
        .wbs_m_we_i(m_we), .wbs_m_dat_i(m_wdat), .wbs_m_sel_i(m_sel),
        .wbs_m_dat_o(m_rdat), .wbs_m_ack_o(m_ack),
        .wbs_s_cyc_o(s_cyc), .wbs_s_stb_o(s_stb), .wbs_s_adr_o(s_adr),
        .wbs_s_we_o(s_we), .wbs_s_dat_o(s_wdat), .wbs_s_sel_o(s_sel),
        .wbs_s_dat_i(s_rdat), .wbs_s_ack_i(s_ack),
        .bus_err_o(bus_err), .err_cnt_o(err_cnt)
    );

    wishbone_1mst_to_nslv_reg #(
        .NB_SLV(NB), .TIMEOUT(16),
        .ADDR_TAB({32'h3003_0000, 32'h3002_0000, 32'h3000_0000, 32'h3000_0000})
    ) u_dut_ovl (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .wbs_m_cyc_i(m_cyc), .wbs_m_stb_i(m_stb), .wbs_m_adr_i(m_adr),
        .wbs_m_we_i(m_we), .wbs_m_dat_i(m_wdat), .wbs_m_sel_i(m_sel),
        .wbs_m_dat_o(o_rdat), .wbs_m_ack_o(o_ack),
        .wbs_s_cyc_o(o_scyc), .wbs_s_stb_o(o_sstb), .wbs_s_adr_o(o_sadr),
        .wbs_s_we_o(o_swe), .wbs_s_dat_o(o_swdat), .wbs_s_sel_o(o_ssel),
        .wbs_s_dat_i(s_rdat), .wbs_s_ack_i(o_sack),
        .bus_err_o(o_err), .err_cnt_o(o_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                             input logic [3:0] sel);
        m_cyc  = 1'b1;
        m_stb  = 1'b1;
        m_adr  = adr;
        m_we   = we;
        m_wdat = dat;
        m_sel  = sel;
    endtask

    task automatic drop_req();
        m_cyc = 1'b0;
        m_stb = 1'b0;
        m_we  = 1'b0;
    endtask

    // One master access; lat = clock edges from strobe to ack seen (-1 if none).
    task automatic wb_access(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                             input logic [3:0] sel, output int lat, output logic [NB-1:0] stb_seen,
                             output int stb_cyc, output logic err, output logic [31:0] wdat_seen,
                             output logic we_seen);
        lat       = -1;
        stb_seen  = '0;
        stb_cyc   = 0;
        err       = 1'b0;
        wdat_seen = '0;
        we_seen   = 1'b0;
        drive_req(adr, we, dat, sel);
        for (int n = 1; n <= 64; n++) begin
            tick();
            stb_seen = stb_seen | s_stb;
            if (s_stb != '0) begin
                stb_cyc++;
                wdat_seen = s_wdat;
                we_seen   = s_we;
            end
            if (m_ack) begin
                lat = n;
                err = bus_err;
                break;
            end
        end
        drop_req();
    endtask

    int            lat, stb_cyc;
    logic [NB-1:0] stb_seen;
    logic          err, we_seen, ack_any;
    logic [31:0]   wdat_seen;

    initial begin
        rst_n    = 1'b0;
        m_cyc    = 1'b0;
        m_stb    = 1'b0;
        m_we     = 1'b0;
        m_adr    = '0;
        m_wdat   = '0;
        m_sel    = '0;
        ack_en   = '1;
        spur_ack = '0;
        slv_dat[0] = 32'h0BAD_F00D;
        slv_dat[1] = 32'h1234_5678;
        slv_dat[2] = 32'hDEAD_BEEF;
        slv_dat[3] = 32'h0303_0303;

        tick();
        tick();
        check("rst_m_ack",   32'(m_ack),   32'h0);
        check("rst_bus_err", 32'(bus_err), 32'h0);
        check("rst_s_cyc",   32'(s_cyc),   32'h0);
        check("rst_s_stb",   32'(s_stb),   32'h0);
        check("rst_m_dat",   m_rdat,       32'h0);
        check("rst_err_cnt", 32'(err_cnt), 32'h0);
        rst_n = 1'b1;
        tick();

        // Read slave1, zero-wait
        wb_access(32'h3001_0004, 1'b0, 32'h0, 4'hF, lat, stb_seen, stb_cyc, err, wdat_seen, we_seen);
        check("rd1_lat",  32'(lat),      32'd3);
        check("rd1_stb",  32'(stb_seen), 32'h2);
        check("rd1_scyc", 32'(stb_cyc),  32'd1);
        check("rd1_dat",  m_rdat,        32'h1234_5678);
        check("rd1_err",  32'(err),      32'h0);
        tick();
        check("rd1_ack_single", 32'(m_ack), 32'h0);

        // Write slave3
        wb_access(32'h3003_0000, 1'b1, 32'hA5A5_A5A5, 4'hF, lat, stb_seen, stb_cyc, err, wdat_seen, we_seen);
        check("wr3_lat",  32'(lat),      32'd3);
        check("wr3_stb",  32'(stb_seen), 32'h8);
        check("wr3_wdat", wdat_seen,     32'hA5A5_A5A5);
        check("wr3_we",   32'(we_seen),  32'h1);
        check("wr3_err",  32'(err),      32'h0);
        tick();
        check("wr3_ack_single", 32'(m_ack), 32'h0);

        // Read slave2
        wb_access(32'h3002_0010, 1'b0, 32'h0, 4'hF, lat, stb_seen, stb_cyc, err, wdat_seen, we_seen);
        check("rd2_stb", 32'(stb_seen), 32'h4);
        check("rd2_dat", m_rdat,        32'hDEAD_BEEF);
        tick();

        // Unmapped read
        wb_access(32'h4000_0000, 1'b0, 32'h0, 4'hF, lat, stb_seen, stb_cyc, err, wdat_seen, we_seen);
        check("unm_lat",  32'(lat),      32'd2);
        check("unm_stb",  32'(stb_seen), 32'h0);
        check("unm_dat",  m_rdat,        32'hBADA_DD00);
        check("unm_err",  32'(err),      32'h1);
        check("unm_cnt",  32'(err_cnt),  32'd1);
        tick();
        check("unm_err_pulse", 32'(bus_err), 32'h0);

        // Master abort while slave0 hangs
        ack_en = '0;
        drive_req(32'h3000_0000, 1'b0, 32'h0, 4'hF);
        tick();
        check("abt_stb", 32'(s_stb), 32'h1);
        check("abt_cyc", 32'(s_cyc), 32'h1);
        tick();
        tick();
        drop_req();
        tick();
        check("abt_stb_drop", 32'(s_stb), 32'h0);
        check("abt_cyc_drop", 32'(s_cyc), 32'h0);
        ack_any = m_ack;
        for (int n = 0; n < 3; n++) begin
            tick();
            ack_any = ack_any | m_ack;
        end
        check("abt_no_ack", 32'(ack_any), 32'h0);
        check("abt_cnt",    32'(err_cnt), 32'd1);
        check("abt_dat_hold", m_rdat,     32'hBADA_DD00);

        // Overlapping map: slave0 wins, spurious slave1 ack ignored
        spur_ack = 4'b0010;
        drive_req(32'h3000_0000, 1'b0, 32'h0, 4'hF);
        tick();
        check("ovl_stb", 32'(o_sstb), 32'h1);
        ack_any = o_ack;
        for (int n = 0; n < 3; n++) begin
            tick();
            ack_any = ack_any | o_ack;
        end
        check("ovl_spur_ign", 32'(ack_any), 32'h0);
        check("ovl_stb_hold", 32'(o_sstb),  32'h1);
        spur_ack = '0;
        ack_en   = 4'b0001;
        ack_any  = 1'b0;
        for (int n = 0; n < 8; n++) begin
            tick();
            if (o_ack) begin
                ack_any = 1'b1;
                break;
            end
        end
        drop_req();
        check("ovl_ack", 32'(ack_any), 32'h1);
        check("ovl_dat", o_rdat,       32'h0BAD_F00D);
        tick();

        // Async reset in REQ
        ack_en = '0;
        drive_req(32'h3001_0000, 1'b0, 32'h0, 4'hF);
        tick();
        tick();
        check("rrq_stb", 32'(s_stb), 32'h2);
        rst_n = 1'b0;
        #1;
        check("rrq_stb0",  32'(s_stb),   32'h0);
        check("rrq_cyc0",  32'(s_cyc),   32'h0);
        check("rrq_ack0",  32'(m_ack),   32'h0);
        check("rrq_dat0",  m_rdat,       32'h0);
        check("rrq_cnt0",  32'(err_cnt), 32'h0);
        drop_req();
        tick();
        rst_n  = 1'b1;
        ack_en = '1;
        tick();
        wb_access(32'h3001_0000, 1'b0, 32'h0, 4'hF, lat, stb_seen, stb_cyc, err, wdat_seen, we_seen);
        check("post_rst_lat", 32'(lat), 32'd3);
        check("post_rst_dat", m_rdat,   32'h1234_5678);
        tick();

`ifdef WB_SPLIT_TIMEOUT_EN
        // Hung slave0 with TIMEOUT=16
        ack_en = '0;
        wb_access(32'h3000_0000, 1'b0, 32'h0, 4'hF, lat, stb_seen, stb_cyc, err, wdat_seen, we_seen);
        check("wd_stb_cyc", 32'(stb_cyc),  32'd16);
        check("wd_lat",     32'(lat),      32'd18);
        check("wd_err",     32'(err),      32'h1);
        check("wd_dat",     m_rdat,        32'hBADA_DD00);
        check("wd_stb",     32'(stb_seen), 32'h1);
        ack_en = '1;
        tick();
`endif

        // Error counter saturation
        for (int k = 0; k < 300; k++) begin
            wb_access(32'h4000_0000 + 32'(k), 1'b0, 32'h0, 4'hF, lat, stb_seen, stb_cyc, err,
                      wdat_seen, we_seen);
            if (lat < 0) begin
                check("sat_lat", 32'(lat), 32'd2);
                break;
            end
            tick();
        end
        check("sat_cnt", 32'(err_cnt), 32'd255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200us;
        $display("FAIL global_timeout: simulation exceeded 200us");
        $fatal(1);
    end

endmodule
